imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream ingress plus instruction-memory write port of the boot loader.
// Pure wiring; no latency. Stream uses byte_valid/byte_ready, the memory port is fire-and-forget.
interface imem_loader_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    // master: the loader (drives memory, sinks the byte stream)
    modport master (
        input  byte_data, byte_valid,
        output byte_ready, mem_addr, mem_en, mem_wr, mem_wdata
    );

    // slave: host byte source plus instruction memory
    modport slave (
        output byte_data, byte_valid,
        input  byte_ready, mem_addr, mem_en, mem_wr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs streamed bytes into 32-bit words and writes them to instruction memory.
// Latency: one write cycle after each 4th byte; >=5 cycles/word. byte_ready drops during WRITE/IDLE/DONE.
// Backpressure: source stalls indefinitely on byte_valid gaps; bytes are only consumed in COLLECT.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int          BIG_ENDIAN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       word_count,
    imem_loader_if.master     bus,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [15:0] idx_q;
    logic [1:0]  bidx_q;
    logic [31:0] asm_q;
    logic        byte_ready_q;
    logic        mem_en_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_reset_n_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] asm_d;
    logic        byte_fire;
    logic        wc_too_big;
    logic        last_word;

    always_comb begin
        asm_d = asm_q;
        if (BIG_ENDIAN != 0) asm_d = {asm_q[23:0], bus.byte_data};
        else                 asm_d = {bus.byte_data, asm_q[31:8]};
    end

    assign byte_fire  = bus.byte_valid && byte_ready_q;
    assign wc_too_big = 32'(word_count) > MAX_WORDS;
    assign last_word  = (idx_q == count_q - 16'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            bidx_q        <= '0;
            asm_q         <= '0;
            byte_ready_q  <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (wc_too_big) begin
                            err_q <= 1'b1;
                        end else if (word_count == 16'd0) begin
                            state_q       <= DONE;
                            done_q        <= 1'b1;
                            cpu_reset_n_q <= 1'b1;
                            busy_q        <= 1'b0;
                        end else begin
                            state_q       <= COLLECT;
                            count_q       <= word_count;
                            err_q         <= 1'b0;
                            idx_q         <= '0;
                            bidx_q        <= '0;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            cpu_reset_n_q <= 1'b0;
                            byte_ready_q  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_fire) begin
                        asm_q  <= asm_d;
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            mem_en_q     <= 1'b1;
                            mem_wr_q     <= 1'b1;
                            mem_addr_q   <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                            mem_wdata_q  <= asm_d;
                        end
                    end
                end
                WRITE: begin
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    idx_q    <= idx_q + 16'd1;
                    if (last_word) begin
                        state_q       <= DONE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        cpu_reset_n_q <= 1'b1;
                    end else begin
                        state_q      <= COLLECT;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_reset_n    = cpu_reset_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load requests plus a mid-load reset sequence.
// Expected writes are queued as bytes are driven and matched when the write port fires.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = '0;
    logic        cpu_reset_n, busy, done, err;

    imem_loader_if bus();

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024),
        .BIG_ENDIAN(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst_first;
        logic [15:0] wc;
        int          gap;
        logic [7:0]  b [8];
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs [6];
    wr_t         sb [$];
    wr_t         mon_e;
    logic [31:0] imem [0:15];
    int          vec_cnt = 0;
    int          miss    = 0;
    int          wr_cnt  = 0;
    bit          err_m   = 1'b0;
    bit          done_m  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset && bus.mem_en) begin
            wr_cnt++;
            chk("write_mem_wr", bus.mem_wr, 1);
            chk("write_byte_ready_low", bus.byte_ready, 0);
            chk("write_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("write_addr", bus.mem_addr, mon_e.addr);
                chk("write_data", bus.mem_wdata, mon_e.data);
            end
            if (bus.mem_addr[31:2] < 30'd16) imem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
    end

    task automatic set_vec(input int i, input bit r, input logic [15:0] wc, input int gap,
                           input logic [63:0] bytes);
        vecs[i].rst_first = r;
        vecs[i].wc        = wc;
        vecs[i].gap       = gap;
        for (int k = 0; k < 8; k++) vecs[i].b[k] = bytes[63-8*k -: 8];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        sb.delete();
        err_m  = 1'b0;
        done_m = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("byte_ready_within_budget", (n < 40), 1);
        @(negedge clock);
    endtask

    task automatic push_word(input int w, input vec_t v);
        wr_t e;
        e.addr = 32'(4 * w);
        e.data = {v.b[4*w], v.b[4*w+1], v.b[4*w+2], v.b[4*w+3]};
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        bit valid;
        int base_wr;
        int n = 0;
        if (v.rst_first) do_reset();
        valid   = (v.wc != 16'd0) && (v.wc <= 16'd1024);
        base_wr = wr_cnt;
        @(negedge clock);
        start      = 1'b1;
        word_count = v.wc;
        @(negedge clock);
        start = 1'b0;
        if (v.wc > 16'd1024) err_m = 1'b1;
        else if (v.wc != 16'd0) begin err_m = 1'b0; done_m = 1'b0; end
        else done_m = 1'b1;
        chk("err_after_start", err, err_m);
        chk("done_after_start", done, done_m);
        chk("cpu_reset_n_after_start", cpu_reset_n, done_m);
        chk("busy_after_start", busy, valid);
        if (valid) begin
            for (int w = 0; w < int'(v.wc); w++) begin
                push_word(w, v);
                for (int k = 0; k < 4; k++) begin
                    send_byte(v.b[4*w+k]);
                    if (v.gap > 0) begin
                        bus.byte_valid = 1'b0;
                        repeat (v.gap) @(negedge clock);
                    end
                end
            end
            bus.byte_valid = 1'b0;
            while (!done && n < 20) begin
                @(negedge clock);
                n++;
            end
            done_m = 1'b1;
        end
        repeat (2) @(negedge clock);
        chk("done_final", done, done_m);
        chk("cpu_reset_n_final", cpu_reset_n, done_m);
        chk("busy_final", busy, 0);
        chk("err_final", err, err_m);
        chk("write_count", wr_cnt - base_wr, valid ? 32'(v.wc) : 32'd0);
        chk("scoreboard_drained", sb.size(), 0);
        if (valid)
            for (int w = 0; w < int'(v.wc); w++)
                chk("imem_readback", imem[w], {v.b[4*w], v.b[4*w+1], v.b[4*w+2], v.b[4*w+3]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t restart;
        int   base_wr;
        bus.byte_data  = '0;
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 32'hFFFF_FFFF;

        set_vec(0, 1'b1, 16'd2,    0, 64'h12345678_AABBCCDD);
        set_vec(1, 1'b0, 16'd2,    3, 64'h12345678_AABBCCDD);
        set_vec(2, 1'b0, 16'd0,    0, 64'h0);
        set_vec(3, 1'b1, 16'd1025, 0, 64'h0);
        set_vec(4, 1'b0, 16'd1,    0, 64'h01020304_00000000);
        set_vec(5, 1'b0, 16'd1,    0, 64'hDEADBEEF_00000000);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset after 6 of 8 bytes: only word 0 may reach memory.
        do_reset();
        restart.rst_first = 1'b0;
        restart.wc        = 16'd2;
        restart.gap       = 0;
        restart.b         = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base_wr = wr_cnt;
        @(negedge clock);
        start      = 1'b1;
        word_count = 16'd2;
        @(negedge clock);
        start = 1'b0;
        push_word(0, vecs[0]);
        for (int k = 0; k < 6; k++) send_byte(vecs[0].b[k]);
        bus.byte_valid = 1'b0;
        chk("partial_busy", busy, 1);
        do_reset();
        chk("partial_write_count", wr_cnt - base_wr, 1);
        chk("partial_word0", imem[0], 32'h12345678);
        run_vec(restart);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
